debounce_a: RTL and testbench
=============================

Name: debounce_a

Overview:
- Input conditioning stage that sits directly upstream of the combinational NOT gate. It feeds the gate's `a` input.
- Takes a raw, asynchronous, bouncy single-bit signal and synchronises it to `clk`.
- Filters out glitches shorter than a programmable number of cycles.
- Outputs a clean level `y` for the gate, plus single-cycle rise/fall pulses and a wrap-around count of accepted rising edges for debug and testbench checking.

Parameters:
- STABLE_CYCLES, 4: number of consecutive cycles the synchronised input must differ from `y` before `y` flips. Legal range is 1 to 65535.
- COUNT_W, 8: width of the accepted-rising-edge counter.

Ports:
- clk  input  1  single system clock; all flops update on its rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  1  raw input, asynchronous to clk and possibly bouncing.
- y  output  1  debounced level; drives the NOT gate input.
- rise  output  1  one-cycle pulse, high in the cycle after `y` goes 0->1.
- fall  output  1  one-cycle pulse, high in the cycle after `y` goes 1->0.
- rise_count  output  COUNT_W  number of accepted 0->1 transitions, modulo 2^COUNT_W.

Behaviour:
- Reset:
  - One clock is single; reset is synchronous and active-high (`rst` sampled on the rising edge of `clk`).
  - While `rst`=1 at an edge: sync flops s1=s2=0, state=STABLE, cnt=0, y=0, rise=0, fall=0, rise_count=0.
  - Reset overrides every other condition in the same edge.
- Synchroniser:
  - 2-flop chain, s1<=a, s2<=s1.
  - Only s2 is used downstream; `a` never reaches other logic directly.
- Counter width: cnt is clog2(STABLE_CYCLES+1) bits and never exceeds STABLE_CYCLES.
- State machine, 2 states, evaluated each edge with `rst`=0:
  - STABLE, s2==y: stay, cnt=0.
  - STABLE, s2!=y: go to PEND, cnt<=1.
  - PEND, s2==y (bounce back): go to STABLE, cnt<=0, y unchanged, no pulse.
  - PEND, s2!=y and cnt<STABLE_CYCLES: cnt<=cnt+1.
  - PEND, s2!=y and cnt==STABLE_CYCLES: y<=~y, go to STABLE, cnt<=0.
    - On this edge, rise<=1 if the new y=1, otherwise fall<=1.
    - rise_count<=rise_count+1 on a rise.
- Pulses:
  - rise and fall are registered and high for exactly one cycle (the cycle following the flip edge).
  - rise and fall are never high simultaneously.
  - Because every flip ends in STABLE, two flips are separated by at least STABLE_CYCLES+1 edges, so pulses can never be back-to-back.
- Latency:
  - If `a` changes and is sampled by s1 at edge t and then holds, s2 differs at edge t+1, PEND is entered at t+2, and y flips at edge t+STABLE_CYCLES+2.
  - The NOT gate output therefore follows by the same amount plus its combinational delay.
- Glitch rejection: any excursion of s2 lasting ≤STABLE_CYCLES cycles produces no change on y, rise, fall or rise_count.
- Wrap-around: rise_count wraps from 2^COUNT_W-1 to 0 with no flag.
- Reset mid-operation: asserting rst while in PEND discards the pending transition; y returns to 0 even if it was 1.
- Post-reset: if `a`=1 is held through reset, y reaches 1 STABLE_CYCLES+2 edges after rst deasserts, and a rise pulse is produced.
- No X propagation: all outputs are defined from the first reset edge onward.

Test Plan:
- Basic rise:
  - Stimulus: STABLE_CYCLES=4; rst high for 2 edges, then a=0 for 5 cycles, then a=1 sampled at edge t and held.
  - Required: y=1 after edge t+6; rise=1 for exactly one cycle after t+6; rise_count=1; fall=0 throughout.
- Glitch rejection:
  - Stimulus: from y=0, a=1 for 3 cycles then back to 0; repeat with 4-cycle pulses.
  - Required: y stays 0; rise never asserted; rise_count=0.
  - Also: a 5-cycle pulse does flip y.
- Fall:
  - Stimulus: from y=1, a=0 held.
  - Required: y=0 after 6 edges; fall=1 for one cycle; rise_count unchanged.
- Bounce train:
  - Stimulus: from y=0, a toggles every 2 cycles for 40 cycles, then holds at 1.
  - Required: y changes only once, 6 edges after the final stable sample; exactly one rise pulse.
- Reset mid-pending:
  - Stimulus: with y=1, set a=0 and assert rst for 1 edge at cnt=2.
  - Required: y=0, rise_count=0 and no fall pulse immediately after reset.
  - With a=0 still held afterwards: no further activity.
- Counter wrap:
  - Stimulus: COUNT_W=8; 256 clean rise/fall cycles, each level held 10 cycles.
  - Required: rise_count reads 255 after the 255th rise and 0 after the 256th.
  - Also: exactly 256 rise and 256 fall pulses counted by the bench.

Source files
------------

// File: rtl/debounce_a.sv
// Debounce stage: synchronises raw input `a`, accepts a level only after it holds for STABLE_CYCLES+1 edges.
// Latency: y flips STABLE_CYCLES+2 edges after the first edge that samples a clean change; no backpressure.
module debounce_a #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a,
  output logic               y,
  output logic               rise,
  output logic               fall,
  output logic [COUNT_W-1:0] rise_count
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_PEND   = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s1;
  logic             s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      state      <= ST_STABLE;
      cnt        <= '0;
      y          <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      rise_count <= '0;
    end else begin
      s1   <= a;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_STABLE: begin
          if (s2 != y) begin
            state <= ST_PEND;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        ST_PEND: begin
          if (s2 == y) begin
            // Bounced back before qualifying: drop the candidate silently.
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt < CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            y     <= ~y;
            state <= ST_STABLE;
            cnt   <= '0;
            if (!y) begin
              rise       <= 1'b1;
              rise_count <= rise_count + COUNT_W'(1);
            end else begin
              fall <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_a.sv
// Bench for debounce_a: run-length reference model checked every cycle, plus hand-computed checkpoints.
module tb_debounce_a;

  localparam int unsigned S  = 4;
  localparam int unsigned CW = 8;

  logic          clk;
  logic          rst;
  logic          a;
  logic          y;
  logic          rise;
  logic          fall;
  logic [CW-1:0] rise_count;

  int vectors;
  int miscompares;
  int n_rise;
  int n_fall;

  // Reference model state
  logic       m_a_d1;
  logic       m_a_d2;
  logic       m_y;
  logic       m_rise;
  logic       m_fall;
  int         m_run;
  int         m_rises;

  debounce_a #(.STABLE_CYCLES(S), .COUNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .y          (y),
    .rise       (rise),
    .fall       (fall),
    .rise_count (rise_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The accepted level changes once the input, seen two edges late, has disagreed with it
  // on S+1 consecutive edges counted from the last flip or reset.
  always @(posedge clk) begin
    if (rst) begin
      m_a_d1  = 1'b0;
      m_a_d2  = 1'b0;
      m_y     = 1'b0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
      m_run   = 0;
      m_rises = 0;
    end else begin
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (m_a_d2 != m_y) m_run = m_run + 1;
      else               m_run = 0;
      if (m_run == S + 1) begin
        m_y   = ~m_y;
        m_run = 0;
        if (m_y) begin
          m_rise  = 1'b1;
          m_rises = m_rises + 1;
        end else begin
          m_fall = 1'b1;
        end
      end
      m_a_d2 = m_a_d1;
      m_a_d1 = a;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n cycles; after each rising edge compare the DUT against the model.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("model_y", {31'd0, y}, {31'd0, m_y});
      chk("model_rise", {31'd0, rise}, {31'd0, m_rise});
      chk("model_fall", {31'd0, fall}, {31'd0, m_fall});
      chk("model_rise_count", {24'd0, rise_count}, 32'(m_rises % (1 << CW)));
      chk("rise_fall_exclusive", {31'd0, rise & fall}, 32'd0);
      if (rise === 1'b1) n_rise = n_rise + 1;
      if (fall === 1'b1) n_fall = n_fall + 1;
    end
  endtask

  int base_rise;
  int base_fall;

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_rise      = 0;
    n_fall      = 0;
    rst = 1'b1;
    a   = 1'b0;

    tick(2);
    chk("reset_y", {31'd0, y}, 32'd0);
    chk("reset_rise", {31'd0, rise}, 32'd0);
    chk("reset_fall", {31'd0, fall}, 32'd0);
    chk("reset_count", {24'd0, rise_count}, 32'd0);
    rst = 1'b0;
    tick(5);

    // Basic rise: sampled at edge t, y must flip at edge t+6
    a = 1'b1;
    tick(6);
    chk("rise_y_early", {31'd0, y}, 32'd0);
    tick(1);
    chk("rise_y", {31'd0, y}, 32'd1);
    chk("rise_pulse", {31'd0, rise}, 32'd1);
    chk("rise_count_1", {24'd0, rise_count}, 32'd1);
    tick(1);
    chk("rise_pulse_end", {31'd0, rise}, 32'd0);
    tick(4);

    // Fall
    a = 1'b0;
    tick(6);
    chk("fall_y_early", {31'd0, y}, 32'd1);
    tick(1);
    chk("fall_y", {31'd0, y}, 32'd0);
    chk("fall_pulse", {31'd0, fall}, 32'd1);
    chk("fall_count_kept", {24'd0, rise_count}, 32'd1);
    tick(1);
    chk("fall_pulse_end", {31'd0, fall}, 32'd0);
    tick(5);

    // Glitches of 3 and 4 cycles are rejected
    for (int len = 3; len <= 4; len++) begin
      a = 1'b1;
      tick(len);
      a = 1'b0;
      tick(12);
      chk("glitch_y", {31'd0, y}, 32'd0);
      chk("glitch_count", {24'd0, rise_count}, 32'd1);
    end

    // A 5-cycle pulse is accepted, then falls back once the input returns low
    a = 1'b1;
    tick(5);
    a = 1'b0;
    tick(2);
    chk("pulse5_y", {31'd0, y}, 32'd1);
    chk("pulse5_rise", {31'd0, rise}, 32'd1);
    chk("pulse5_count", {24'd0, rise_count}, 32'd2);
    tick(12);
    chk("pulse5_back_low", {31'd0, y}, 32'd0);

    // Bounce train: 40 cycles toggling every 2, then held high
    base_rise = n_rise;
    for (int i = 0; i < 10; i++) begin
      a = 1'b1;
      tick(2);
      a = 1'b0;
      tick(2);
    end
    chk("bounce_y_quiet", {31'd0, y}, 32'd0);
    a = 1'b1;
    tick(6);
    chk("bounce_y_early", {31'd0, y}, 32'd0);
    tick(1);
    chk("bounce_y", {31'd0, y}, 32'd1);
    chk("bounce_count", {24'd0, rise_count}, 32'd3);
    tick(5);
    chk("bounce_one_rise", 32'(n_rise - base_rise), 32'd1);

    // Reset arriving while a fall is pending (cnt=2)
    a = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_y", {31'd0, y}, 32'd0);
    chk("midrst_count", {24'd0, rise_count}, 32'd0);
    chk("midrst_fall", {31'd0, fall}, 32'd0);
    base_fall = n_fall;
    tick(20);
    chk("midrst_quiet_y", {31'd0, y}, 32'd0);
    chk("midrst_no_fall", 32'(n_fall - base_fall), 32'd0);

    // Counter wrap over 256 clean rise/fall cycles
    base_rise = n_rise;
    base_fall = n_fall;
    for (int i = 0; i < 256; i++) begin
      a = 1'b1;
      tick(10);
      if (i == 254) chk("wrap_255", {24'd0, rise_count}, 32'd255);
      if (i == 255) chk("wrap_0", {24'd0, rise_count}, 32'd0);
      a = 1'b0;
      tick(10);
    end
    chk("wrap_rises", 32'(n_rise - base_rise), 32'd256);
    chk("wrap_falls", 32'(n_fall - base_fall), 32'd256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
